// File: rtl/smc_stream.sv
// smc_stream - frame-based MOSFET calculator.
//   Accepts N devices (W, V_GS, V_DS), one per accepted beat. Each device is
//   turned into I_D or g_m, inserted into a descending sort array, and once the
//   frame is complete a sum (g_m) or 3/4/5-weighted sum (I_D) of the largest
//   or smallest three values is emitted with a one-cycle strobe.
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   in_valid           beat valid; accepted in IDLE/LOAD only
//   mode[1:0]          [0] 1=I_D 0=g_m, [1] 1=largest 3 0=smallest 3 (first beat)
//   W, V_GS, V_DS      device parameters, DW bits each
//   out_valid, out_n   result strobe and result (0 when not valid)
// Optional macro SMC_OUT_IDX_EN adds out_idx[3:0]: arrival index of s0 (top
// mode) or of the smallest device (bottom mode), lowest index on ties.
module smc_stream #(
    parameter int N  = 6,
    parameter int DW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [1:0]      mode,
    input  logic [DW-1:0]   W,
    input  logic [DW-1:0]   V_GS,
    input  logic [DW-1:0]   V_DS,
    output logic            out_valid,
    output logic [3*DW+4:0] out_n
`ifdef SMC_OUT_IDX_EN
    ,
    output logic [3:0]      out_idx
`endif
);
    localparam int VW = 3 * DW + 1;
    localparam int OW = VW + 4;
    localparam int CW = 5;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_t;

    function automatic logic [VW-1:0] dev_value(input logic is_id, input logic [DW-1:0] w,
                                                input logic [DW-1:0] vgs, input logic [DW-1:0] vds);
        logic [VW-1:0] wv, gv, dv, vov, prod;
        wv  = VW'(w);
        gv  = VW'(vgs);
        dv  = VW'(vds);
        vov = gv - VW'(1);
        if (vgs == '0)
            prod = '0;
        else if (gv > dv + VW'(1))
            prod = is_id ? wv * dv * ((vov << 1) - dv) : (wv << 1) * dv;
        else
            prod = is_id ? wv * vov * vov : (wv << 1) * vov;
        return prod / VW'(3);
    endfunction

    function automatic logic [OW-1:0] combine(input logic weighted, input logic [VW-1:0] a,
                                              input logic [VW-1:0] b, input logic [VW-1:0] c);
        logic [OW-1:0] ea, eb, ec;
        ea = OW'(a);
        eb = OW'(b);
        ec = OW'(c);
        if (weighted)
            return (ea << 1) + ea + (eb << 2) + (ec << 2) + ec;
        return ea + eb + ec;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            drn_q, drn_d;
    logic [1:0]      mode_q, mode_d;
    logic            vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
    logic [DW-1:0]   w_p0_q, w_p0_d, vgs_p0_q, vgs_p0_d, vds_p0_q, vds_p0_d;
    logic [VW-1:0]   val_p1_q, val_p1_d;
    logic [N-1:0]    occ_q, occ_d;
    logic [VW-1:0]   sv_q [N];
    logic [VW-1:0]   sv_d [N];
    logic            out_valid_q, out_valid_d;
    logic [OW-1:0]   out_n_q, out_n_d;
    logic            accept, first;
    logic [N-1:0]    take;
    logic [VW-1:0]   s0, s1, s2;
`ifdef SMC_OUT_IDX_EN
    logic [3:0]      idx_p0_q, idx_p0_d, idx_p1_q, idx_p1_d;
    logic [3:0]      sidx_q [N];
    logic [3:0]      sidx_d [N];
    logic [3:0]      out_idx_q, out_idx_d;
`endif

    always_comb begin
        accept  = in_valid && (state_q == S_IDLE || state_q == S_LOAD);
        first   = in_valid && (state_q == S_IDLE);
        state_d = state_q;
        cnt_d   = cnt_q;
        drn_d   = drn_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                state_d = S_LOAD;
                cnt_d   = CW'(1);
                mode_d  = mode;
            end
            S_LOAD: if (in_valid) begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    drn_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                drn_d = 1'b1;
                if (drn_q) state_d = S_OUT;
            end
            default: state_d = S_IDLE;
        endcase

        // Stage p0: capture the accepted beat.
        vld_p0_d = accept;
        w_p0_d   = W;
        vgs_p0_d = V_GS;
        vds_p0_d = V_DS;
`ifdef SMC_OUT_IDX_EN
        idx_p0_d = first ? 4'd0 : cnt_q[3:0];
        idx_p1_d = idx_p0_q;
`endif

        // Stage p1: per-device value.
        vld_p1_d = vld_p0_q;
        val_p1_d = dev_value(mode_q[0], w_p0_q, vgs_p0_q, vds_p0_q);

        // Stage p2: insert into the sort array. take[i] marks slots at or
        // below the insertion point; strict '<' keeps earlier ties above.
        for (int i = 0; i < N; i++)
            take[i] = !occ_q[i] || (sv_q[i] < val_p1_q);
        sv_d  = sv_q;
        occ_d = occ_q;
`ifdef SMC_OUT_IDX_EN
        sidx_d = sidx_q;
`endif
        if (first) begin
            occ_d = '0;
        end else if (vld_p1_q) begin
            if (take[0]) begin
                sv_d[0]  = val_p1_q;
                occ_d[0] = 1'b1;
`ifdef SMC_OUT_IDX_EN
                sidx_d[0] = idx_p1_q;
`endif
            end
            for (int i = 1; i < N; i++) begin
                if (take[i]) begin
                    occ_d[i] = take[i-1] ? occ_q[i-1] : 1'b1;
                    sv_d[i]  = take[i-1] ? sv_q[i-1] : val_p1_q;
`ifdef SMC_OUT_IDX_EN
                    sidx_d[i] = take[i-1] ? sidx_q[i-1] : idx_p1_q;
`endif
                end
            end
        end

        // Stage out: select three entries and form the result.
        if (mode_q[1]) begin
            s0 = sv_q[0];
            s1 = sv_q[1];
            s2 = sv_q[2];
        end else begin
            s0 = sv_q[N-3];
            s1 = sv_q[N-2];
            s2 = sv_q[N-1];
        end
        out_valid_d = (state_q == S_OUT);
        out_n_d     = (state_q == S_OUT) ? combine(mode_q[0], s0, s1, s2) : '0;
`ifdef SMC_OUT_IDX_EN
        // Equal values sit in arrival order, so the topmost copy of the
        // minimum is the earliest arrival.
        out_idx_d = sidx_q[0];
        if (!mode_q[1]) begin
            out_idx_d = sidx_q[N-1];
            for (int i = N - 1; i >= 0; i--)
                if (sv_q[i] == sv_q[N-1]) out_idx_d = sidx_q[i];
        end
        if (state_q != S_OUT) out_idx_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            drn_q       <= 1'b0;
            mode_q      <= '0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            for (int i = 0; i < N; i++) sv_q[i] <= '0;
`ifdef SMC_OUT_IDX_EN
            out_idx_q   <= '0;
            for (int i = 0; i < N; i++) sidx_q[i] <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drn_q       <= drn_d;
            mode_q      <= mode_d;
            vld_p0_q    <= vld_p0_d;
            vld_p1_q    <= vld_p1_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            out_n_q     <= out_n_d;
            sv_q        <= sv_d;
`ifdef SMC_OUT_IDX_EN
            out_idx_q   <= out_idx_d;
            sidx_q      <= sidx_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        w_p0_q   <= w_p0_d;
        vgs_p0_q <= vgs_p0_d;
        vds_p0_q <= vds_p0_d;
        val_p1_q <= val_p1_d;
`ifdef SMC_OUT_IDX_EN
        idx_p0_q <= idx_p0_d;
        idx_p1_q <= idx_p1_d;
`endif
    end

    assign out_valid = out_valid_q;
    assign out_n     = out_n_q;
`ifdef SMC_OUT_IDX_EN
    assign out_idx   = out_idx_q;
`endif

endmodule

// File: tb/tb_smc_stream.sv
module tb_smc_stream;
    localparam int N  = 6;
    localparam int DW = 3;
    localparam int OW = 3 * DW + 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] W = '0, V_GS = '0, V_DS = '0;
    logic          out_valid;
    logic [OW-1:0] out_n;
`ifdef SMC_OUT_IDX_EN
    logic [3:0]    out_idx;
`endif

    smc_stream #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
        .W(W), .V_GS(V_GS), .V_DS(V_DS),
        .out_valid(out_valid), .out_n(out_n)
`ifdef SMC_OUT_IDX_EN
        , .out_idx(out_idx)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    typedef struct {int due; int val; int idx;} exp_t;
    exp_t expq[$];

    int fw[16], fg[16], fd[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Device value straight from the device equations.
    function automatic int dev_val(input int w, input int g, input int d, input bit is_id);
        int vov;
        vov = g - 1;
        if (g == 0) return 0;
        if (g > d + 1) return is_id ? (w * d * (2 * vov - d)) / 3 : (2 * w * d) / 3;
        return is_id ? (w * vov * vov) / 3 : (2 * w * vov) / 3;
    endfunction

    task automatic model(input logic [1:0] md, output int res, output int idx);
        int v[16];
        int srt[16];
        int a, b, c, t, target;
        for (int i = 0; i < N; i++) begin
            v[i] = dev_val(fw[i], fg[i], fd[i], md[0]);
            srt[i] = v[i];
        end
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (srt[j] > srt[i]) begin t = srt[i]; srt[i] = srt[j]; srt[j] = t; end
        if (md[1]) begin a = srt[0]; b = srt[1]; c = srt[2]; end
        else begin a = srt[N-3]; b = srt[N-2]; c = srt[N-1]; end
        res = md[0] ? (3 * a + 4 * b + 5 * c) : (a + b + c);
        target = md[1] ? srt[0] : srt[N-1];
        idx = 0;
        for (int i = N - 1; i >= 0; i--) if (v[i] == target) idx = i;
    endtask

    // gap < 0 means random 0..2 idle cycles between beats.
    task automatic send_frame(input logic [1:0] md, input int gap, input bit toggle,
                              input bit busy, output int res, output int idx);
        exp_t e;
        int g;
        model(md, res, idx);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            W = DW'(fw[i]); V_GS = DW'(fg[i]); V_DS = DW'(fd[i]);
            mode = (toggle && i > 0) ? ~md : md;
            @(posedge clk); #1;
            in_valid = 1'b0;
            W = DW'($urandom_range(0, 7)); V_GS = DW'($urandom_range(0, 7));
            mode = 2'($urandom_range(0, 3));
            if (i < N - 1) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (g) begin @(posedge clk); #1; end
            end
        end
        e.due = cyc + 3; e.val = res; e.idx = idx;
        expq.push_back(e);
        repeat (3) begin
            in_valid = busy;
            W = DW'($urandom_range(0, 7)); V_GS = DW'($urandom_range(0, 7)); V_DS = DW'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic fill(input int w, input int g, input int d);
        for (int i = 0; i < N; i++) begin fw[i] = w; fg[i] = g; fd[i] = d; end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                check("out_valid_strobe", 32'(out_valid), 32'd1);
                check("out_n_result", 32'(out_n), expq[0].val);
`ifdef SMC_OUT_IDX_EN
                check("out_idx_result", 32'(out_idx), expq[0].idx);
`endif
                void'(expq.pop_front());
            end else begin
                check("out_valid_quiet", 32'(out_valid), 32'd0);
                check("out_n_quiet", 32'(out_n), 32'd0);
`ifdef SMC_OUT_IDX_EN
                check("out_idx_quiet", 32'(out_idx), 32'd0);
`endif
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int res, idx;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_n", 32'(out_n), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        fill(1, 3, 1);
        send_frame(2'b11, 0, 1'b0, 1'b0, res, idx);
        check("pin_triode_id", res, 12);

        fill(7, 7, 7);
        send_frame(2'b10, 0, 1'b0, 1'b0, res, idx);
        check("pin_sat_gm", res, 84);

        for (int i = 0; i < N; i++) begin fw[i] = i + 1; fg[i] = 2; fd[i] = 7; end
        send_frame(2'b00, 0, 1'b0, 1'b0, res, idx);
        check("pin_small_gm", res, 3);
        check("pin_small_idx", idx, 0);

        fill(1, 3, 1);
        send_frame(2'b11, 2, 1'b1, 1'b0, res, idx);
        check("pin_gaps_toggle", res, 12);

        // Partial frame, then a one-cycle reset.
        fill(7, 7, 7);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; W = 3'd5; V_GS = 3'd6; V_DS = 3'd1; mode = 2'b11;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(2'b10, 0, 1'b0, 1'b0, res, idx);
        check("pin_after_reset", res, 84);

        for (int i = 0; i < N; i++) begin fw[i] = int'($urandom_range(0, 7)); fg[i] = 0; fd[i] = int'($urandom_range(0, 7)); end
        send_frame(2'b11, 0, 1'b0, 1'b1, res, idx);
        check("pin_cutoff", res, 0);
        fill(7, 7, 7);
        send_frame(2'b10, 1, 1'b0, 1'b0, res, idx);
        check("pin_after_busy", res, 84);

        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < N; i++) begin
                fw[i] = int'($urandom_range(0, 7));
                fg[i] = int'($urandom_range(0, 7));
                fd[i] = int'($urandom_range(0, 7));
            end
            if (f % 5 == 0) begin fg[1] = fg[0]; fw[1] = fw[0]; fd[1] = fd[0]; end
            send_frame(2'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), res, idx);
        end

        repeat (5) @(posedge clk);
        #1;
        check("no_pending_results", expq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
